// File: rtl/sha2_block_engine.sv
// Iterative SHA-2 compression engine (SHA-256 / SHA-512), one round per clock.
// Message words stream in for t<16; later schedule words are expanded on the fly.
module sha2_block_engine #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_SIZE-1:0]     msg_word,
  input  logic                     msg_valid,
  input  logic                     msg_first,
  output logic                     msg_ready,
  input  logic [8*WORD_SIZE-1:0]   iv,
  output logic [6:0]               k_index,
  input  logic [WORD_SIZE-1:0]     k_value,
  output logic                     busy,
  output logic [8*WORD_SIZE-1:0]   digest,
  output logic                     digest_valid
);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);
  localparam bit WIDE = (WORD_SIZE == 64);
  localparam int BS0_A = WIDE ? 28 : 2;
  localparam int BS0_B = WIDE ? 34 : 13;
  localparam int BS0_C = WIDE ? 39 : 22;
  localparam int BS1_A = WIDE ? 14 : 6;
  localparam int BS1_B = WIDE ? 18 : 11;
  localparam int BS1_C = WIDE ? 41 : 25;
  localparam int SS0_A = WIDE ? 1  : 7;
  localparam int SS0_B = WIDE ? 8  : 18;
  localparam int SS0_C = WIDE ? 7  : 3;
  localparam int SS1_A = WIDE ? 19 : 17;
  localparam int SS1_B = WIDE ? 61 : 19;
  localparam int SS1_C = WIDE ? 6  : 10;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  function automatic word_t big_s0(input word_t x);
    return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
  endfunction

  function automatic word_t big_s1(input word_t x);
    return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
  endfunction

  function automatic word_t small_s0(input word_t x);
    return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_C);
  endfunction

  function automatic word_t small_s1(input word_t x);
    return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_C);
  endfunction

  state_t     state_q, state_d;
  logic [6:0] t_q, t_d;
  word_t      hbase_q  [8];
  word_t      hbase_d  [8];
  word_t      work_q   [8];
  word_t      work_d   [8];
  word_t      sched_q  [16];
  word_t      sched_d  [16];
  word_t      digest_q [8];
  word_t      digest_d [8];
  logic       dvalid_q, dvalid_d;

  word_t      base_sel  [8];
  word_t      round_in  [8];
  word_t      round_out [8];
  word_t      w_cur, t1, t2;
  logic       round_en, word0_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      dvalid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hbase_q[i]  <= '0;
        work_q[i]   <= '0;
        digest_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) sched_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      dvalid_q <= dvalid_d;
      hbase_q  <= hbase_d;
      work_q   <= work_d;
      digest_q <= digest_d;
      sched_q  <= sched_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (msg_valid) state_d = ROUND;
      ROUND:   if (t_q == T_LAST) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    busy      = 1'b0;
    k_index   = '0;
    case (state_q)
      IDLE:  msg_ready = 1'b1;
      ROUND: begin
        msg_ready = (t_q < 7'd16);
        busy      = 1'b1;
        k_index   = t_q;
      end
      FINAL: busy = 1'b1;
      default: ;
    endcase
  end

  // Round 0 runs straight off the chaining value so no extra load cycle is needed.
  always_comb begin
    word0_hs = (state_q == IDLE) && msg_valid;
    round_en = word0_hs || ((state_q == ROUND) && ((t_q >= 7'd16) || msg_valid));
    for (int i = 0; i < 8; i++) begin
      base_sel[i] = msg_first ? iv[(7-i)*WORD_SIZE +: WORD_SIZE] : digest_q[i];
      round_in[i] = (state_q == IDLE) ? base_sel[i] : work_q[i];
    end
    // sched_q[15] is W[t-1], sched_q[0] is W[t-16]
    w_cur = (t_q < 7'd16) ? msg_word
          : small_s1(sched_q[14]) + sched_q[9] + small_s0(sched_q[1]) + sched_q[0];
    t1 = round_in[7] + big_s1(round_in[4])
       + ((round_in[4] & round_in[5]) ^ (~round_in[4] & round_in[6]))
       + k_value + w_cur;
    t2 = big_s0(round_in[0])
       + ((round_in[0] & round_in[1]) ^ (round_in[0] & round_in[2]) ^ (round_in[1] & round_in[2]));
    round_out[0] = t1 + t2;
    round_out[1] = round_in[0];
    round_out[2] = round_in[1];
    round_out[3] = round_in[2];
    round_out[4] = round_in[3] + t1;
    round_out[5] = round_in[4];
    round_out[6] = round_in[5];
    round_out[7] = round_in[6];
  end

  always_comb begin
    t_d      = t_q;
    dvalid_d = dvalid_q;
    hbase_d  = hbase_q;
    work_d   = work_q;
    sched_d  = sched_q;
    digest_d = digest_q;
    if (round_en) begin
      work_d = round_out;
      for (int i = 0; i < 15; i++) sched_d[i] = sched_q[i+1];
      sched_d[15] = w_cur;
      t_d = (t_q == T_LAST) ? 7'd0 : t_q + 7'd1;
    end
    if (word0_hs) begin
      hbase_d  = base_sel;
      dvalid_d = 1'b0;
    end
    if (state_q == FINAL) begin
      for (int i = 0; i < 8; i++) digest_d[i] = hbase_q[i] + work_q[i];
      dvalid_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) digest[(7-i)*WORD_SIZE +: WORD_SIZE] = digest_q[i];
  end

  assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_sha2_block_engine.sv
// Directed-vector bench for sha2_block_engine: SHA-256 and SHA-512 instances
// driven from a shared K table, checked against published digests.
module tb_sha2_block_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] k512 [0:79];
  logic [63:0] blk [0:15];
  int checks = 0;
  int errors = 0;

  logic [31:0]  w32, kv32;
  logic         v32, f32, r32, b32, dv32;
  logic [6:0]   ki32;
  logic [255:0] d32;
  logic [63:0]  w64, kv64;
  logic         v64, f64, r64, b64, dv64;
  logic [6:0]   ki64;
  logic [511:0] d64;

  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO256 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  assign kv32 = k512[ki32][63:32];
  assign kv64 = k512[ki64];

  sha2_block_engine #(.WORD_SIZE(32), .ROUNDS(64)) u_sha256 (
    .clk(clk), .rst_n(rst_n), .msg_word(w32), .msg_valid(v32), .msg_first(f32),
    .msg_ready(r32), .iv(IV256), .k_index(ki32), .k_value(kv32), .busy(b32),
    .digest(d32), .digest_valid(dv32));

  sha2_block_engine #(.WORD_SIZE(64), .ROUNDS(80)) u_sha512 (
    .clk(clk), .rst_n(rst_n), .msg_word(w64), .msg_valid(v64), .msg_first(f64),
    .msg_ready(r64), .iv(IV512), .k_index(ki64), .k_value(kv64), .busy(b64),
    .digest(d64), .digest_valid(dv64));

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int s); return (s == 0) ? r32 : r64; endfunction
  function automatic logic bsy(input int s); return (s == 0) ? b32 : b64; endfunction
  function automatic logic dvl(input int s); return (s == 0) ? dv32 : dv64; endfunction
  function automatic logic [6:0] kix(input int s); return (s == 0) ? ki32 : ki64; endfunction

  task automatic drive(input int s, input logic v, input logic [63:0] w, input logic f);
    if (s == 0) begin v32 = v; w32 = w[31:0]; f32 = f; end
    else begin v64 = v; w64 = w; f64 = f; end
  endtask

  task automatic push(input int s, input logic [63:0] w, input logic f);
    int n = 0;
    drive(s, 1'b1, w, f);
    @(negedge clk);
    while (!rdy(s) && n < 200) begin @(negedge clk); n++; end
    if (!rdy(s)) check("push_timeout", 512'(rdy(s)), 512'd1);
    @(posedge clk); #1;
    drive(s, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic run_block(input int s, input logic first, input bit stall,
                           input int exp_lat, input string tag);
    int n;
    int bad_k = 0;
    int bad_r = 0;
    for (int j = 0; j < 16; j++) begin
      if (stall && (j % 2 == 1)) begin
        drive(s, 1'b0, 64'hffff_ffff_ffff_ffff, 1'b1);
        repeat (3) begin
          @(posedge clk); #1;
          if (kix(s) != 7'(j)) bad_k++;
        end
      end
      push(s, blk[j], (j == 0) ? first : 1'b0);
      if (j == 0) check({tag, "_dv_clr"}, 512'(dvl(s)), 512'd0);
    end
    // keep offering junk words: none may be taken until the block is done
    drive(s, 1'b1, 64'ha5a5_a5a5_a5a5_a5a5, 1'b1);
    n = 0;
    while (!dvl(s) && n < 300) begin
      if (rdy(s) || !bsy(s)) bad_r++;
      @(posedge clk); #1;
      n++;
    end
    drive(s, 1'b0, 64'h0, 1'b0);
    check({tag, "_latency"}, 512'(n), 512'(exp_lat));
    check({tag, "_backpressure"}, 512'(bad_r), 512'd0);
    if (stall) check({tag, "_kfrozen"}, 512'(bad_k), 512'd0);
  endtask

  task automatic load_abc(input int s);
    for (int j = 0; j < 16; j++) blk[j] = 64'h0;
    blk[0]  = (s == 0) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
    blk[15] = 64'h18;
  endtask

  initial begin
    k512 = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
    drive(0, 1'b0, 64'h0, 1'b0);
    drive(1, 1'b0, 64'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 512'(r32), 512'd1);
    check("rst_busy", 512'(b32), 512'd0);
    check("rst_dvalid", 512'(dv32), 512'd0);
    check("rst_digest", 512'(d32), 512'd0);
    check("rst_kindex", 512'(ki32), 512'd0);
    check("rst_dvalid512", 512'(dv64), 512'd0);

    load_abc(0);
    run_block(0, 1'b1, 1'b0, 49, "abc256");
    check("abc256_digest", 512'(d32), 512'(ABC256));

    run_block(0, 1'b1, 1'b1, 49, "stall256");
    check("stall256_digest", 512'(d32), 512'(ABC256));

    for (int j = 0; j < 14; j++)
      blk[j] = {32'h0, 8'(8'h61 + j), 8'(8'h62 + j), 8'(8'h63 + j), 8'(8'h64 + j)};
    blk[14] = 64'h8000_0000;
    blk[15] = 64'h0;
    run_block(0, 1'b1, 1'b0, 49, "two_b1");
    for (int j = 0; j < 16; j++) blk[j] = 64'h0;
    blk[15] = 64'h1c0;
    run_block(0, 1'b0, 1'b0, 49, "two_b2");
    check("two256_digest", 512'(d32), 512'(TWO256));

    load_abc(0);
    for (int j = 0; j < 10; j++) push(0, blk[j], (j == 0));
    check("mid_busy_before", 512'(b32), 512'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dvalid", 512'(dv32), 512'd0);
    check("mid_rst_busy", 512'(b32), 512'd0);
    check("mid_rst_digest", 512'(d32), 512'd0);
    check("mid_rst_ready", 512'(r32), 512'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    run_block(0, 1'b1, 1'b0, 49, "after_rst");
    check("after_rst_digest", 512'(d32), 512'(ABC256));

    load_abc(1);
    run_block(1, 1'b1, 1'b0, 65, "abc512");
    check("abc512_digest", d64, ABC512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_block_engine.md
Name: sha2_block_engine

Overview:
Iterative, one-round-per-cycle SHA-2 compression engine built around the existing round-operator datapath. WORD_SIZE selects SHA-256 (32) or SHA-512 (64). The engine consumes 16 message words per block over a valid/ready stream and expands the message schedule on the fly. It chains multi-block messages internally and presents the 8-word digest to the surrounding hash controller.

Parameters:
WORD_SIZE, 32, word width; only 32 (SHA-256, ROUNDS=64) and 64 (SHA-512, ROUNDS=80) are legal.
ROUNDS, 64, round count; must be 64 when WORD_SIZE=32 and 80 when WORD_SIZE=64.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
msg_word  in  WORD_SIZE  message word W[t], big-endian word order within the block
msg_valid  in  1  msg_word is valid
msg_first  in  1  qualifies word 0 only: 1 = first block of a message (chain from iv), 0 = chain from previous digest
msg_ready  out  1  engine accepts a word this cycle
iv  in  8*WORD_SIZE  initial hash; H0 in the MSBs; sampled on word-0 handshake when msg_first=1
k_index  out  7  round index t for the external K-constant ROM
k_value  in  WORD_SIZE  K[k_index], combinational, same cycle
busy  out  1  a block is in progress (ROUND or FINAL)
digest  out  8*WORD_SIZE  H0..H7, with H0 in the MSBs
digest_valid  out  1  digest holds the result of the last completed block

Behaviour:
- States: IDLE, ROUND, FINAL. Round counter t is 0..ROUNDS-1.
- Handshake: a word is accepted on a rising edge where msg_valid && msg_ready.
- msg_ready = 1 in IDLE, and in ROUND while t<16. It is 0 in ROUND for t>=16 and 0 in FINAL.
- k_index = t in ROUND, and 0 in IDLE and FINAL.
- IDLE, on word-0 handshake:
  - H_base <= msg_first ? iv : digest.
  - Apply round 0 with H_base as the a..h inputs, W=msg_word and K=k_value.
  - Store msg_word in schedule slot, set t <= 1, go to ROUND, and clear digest_valid.
- ROUND, t<16:
  - Each handshake applies round t to the working registers with W=msg_word, pushes the word into the 16-entry schedule shift register, and sets t <= t+1.
  - Without a handshake, all state holds (stall), for any number of cycles.
- ROUND, t>=16:
  - W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^WORD_SIZE.
  - Apply the round and shift W[t] into the schedule.
  - After t=ROUNDS-1, go to FINAL.
- Round function: standard SHA-2.
  - T1 = h + S1(e) + Ch(e,f,g) + K + W.
  - T2 = S0(a) + Maj(a,b,c).
  - All additions wrap mod 2^WORD_SIZE.
- Rotate/shift amounts for WORD_SIZE=32:
  - S0 = rotr 2,13,22; S1 = rotr 6,11,25.
  - s0 = rotr 7,18 ^ shr 3; s1 = rotr 17,19 ^ shr 10.
- Rotate/shift amounts for WORD_SIZE=64:
  - S0 = rotr 28,34,39; S1 = rotr 14,18,41.
  - s0 = rotr 1,8 ^ shr 7; s1 = rotr 19,61 ^ shr 6.
- FINAL (1 cycle): digest[i] <= H_base[i] + working[i] mod 2^WORD_SIZE, set digest_valid <= 1, go to IDLE.
- Latency, no stalls: digest_valid rises ROUNDS-15 edges after the word-15 handshake. This is 49 cycles for SHA-256 and 65 for SHA-512. Minimum block period is ROUNDS+1 cycles.
- digest_valid is level: it stays 1 and digest stays stable until the next word-0 handshake.
- The next block's word 0 may be accepted in the first IDLE cycle after FINAL (back-to-back).
- msg_first is ignored for words 1..15.
- busy = 1 in ROUND and FINAL.
- msg_word and msg_first values are don't-care when no handshake occurs.
- Reset (any time, including mid-block):
  - state=IDLE, t=0, msg_ready=1 after release, busy=0, digest_valid=0.
  - digest, H_base, working registers and schedule all return to 0.
  - A partial block is discarded.
  - A block issued after reset with msg_first=0 chains from the zero digest; this is defined behaviour, not an error.

Test Plan:
- SHA-256 "abc", WORD_SIZE=32, msg_first=1, standard IV, one padded block (61626380, 14 zero words, 00000018), msg_valid held 1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid rises exactly 49 cycles after the word-15 handshake.
- SHA-256 two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with msg_first=1, block 2 back-to-back with msg_first=0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; digest_valid drops on the block-2 word-0 handshake.
- SHA-512 "abc", WORD_SIZE=64, ROUNDS=80, standard IV -> digest starts ddaf35a193617aba and ends a54ca49f; latency is 65 cycles after word 15.
- Stall: repeat the SHA-256 "abc" case with msg_valid low for 3 cycles before every odd word -> same digest; no word lost or duplicated; k_index stays frozen during stalls.
- Reset mid-block: assert rst_n=0 after word 9 -> digest_valid=0, busy=0 and digest=0 immediately (asynchronous); then a full "abc" block with msg_first=1 -> correct digest.
- Backpressure check: msg_valid held 1 throughout the block -> msg_ready=0 for t>=16 and in FINAL, and exactly 16 words are consumed per block.
